// File: rtl/tmds_pkg.sv
// Shared TMDS types, control tokens and bit-count helpers.
// Latency: none (types and combinational functions only).
// Backpressure: not applicable.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  // Blanking tokens, indexed by {C1, C0}; bit 0 is transmitted first.
  localparam tmds_sym_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    tmds_sym_t t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: transition minimising (stage 1) then DC balancing with running disparity (stage 2).
// Latency: 2 enabled cycles from data_i/de_i/c_i to sym_o.
// Backpressure: none; every register advances only when en_i is high and holds otherwise.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int DISP_WIDTH = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic       de_i,
  input  logic [1:0] c_i,
  output logic [9:0] sym_o
);

  localparam int W = DISP_WIDTH;

  // Stage 1 combinational results
  logic [3:0] n1_data;
  logic       use_xnor;
  logic [8:0] q_m_d;
  logic [3:0] n1_qm_d;

  // Stage 1 registers
  logic [8:0] q_m_q;
  logic [3:0] n1_q;
  logic [3:0] n0_q;
  logic       de_q;
  logic [1:0] c_q;

  // Stage 2 combinational results and registers
  logic signed [W-1:0] n1_s;
  logic signed [W-1:0] n0_s;
  logic signed [W-1:0] two_q8;
  logic signed [W-1:0] two_nq8;
  logic signed [W-1:0] cnt_d;
  logic signed [W-1:0] cnt_q;
  tmds_sym_t           sym_d;
  tmds_sym_t           sym_q;

  // Stage 1: choose XOR/XNOR chaining to minimise transitions within the byte
  always_comb begin
    logic acc;
    n1_data  = popcount8(data_i);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_i[0]);
    q_m_d    = '0;
    acc      = data_i[0];
    q_m_d[0] = acc;
    for (int i = 1; i < 8; i++) begin
      acc      = use_xnor ? ~(acc ^ data_i[i]) : (acc ^ data_i[i]);
      q_m_d[i] = acc;
    end
    q_m_d[8] = ~use_xnor;
    n1_qm_d  = popcount8(q_m_d[7:0]);
  end

  // Stage 1 register: q_m with its ones/zeros counts and the aligned control bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_m_q <= '0;
      n1_q  <= '0;
      n0_q  <= '0;
      de_q  <= 1'b0;
      c_q   <= 2'b00;
    end else if (en_i) begin
      q_m_q <= q_m_d;
      n1_q  <= n1_qm_d;
      n0_q  <= 4'd8 - n1_qm_d;
      de_q  <= de_i;
      c_q   <= c_i;
    end
  end

  // Stage 2: pick inversion to pull the running disparity toward zero, or emit a control token
  always_comb begin
    n1_s    = signed'({{(W-4){1'b0}}, n1_q});
    n0_s    = signed'({{(W-4){1'b0}}, n0_q});
    two_q8  = signed'({{(W-2){1'b0}}, q_m_q[8], 1'b0});
    two_nq8 = signed'({{(W-2){1'b0}}, ~q_m_q[8], 1'b0});
    sym_d   = CTRL_TOKEN_00;
    cnt_d   = '0;
    if (!de_q) begin
      // Blanking restarts the disparity so the next active line begins balanced
      sym_d = ctrl_token(c_q);
      cnt_d = '0;
    end else if ((cnt_q == '0) || (n1_q == n0_q)) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d = q_m_q[8] ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
    end else if ((!cnt_q[W-1] && (n1_q > n0_q)) || (cnt_q[W-1] && (n0_q > n1_q))) begin
      // cnt is non-zero here, so a clear sign bit means strictly positive
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + two_q8 + n0_s - n1_s;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q - two_nq8 + n1_s - n0_s;
    end
  end

  // Stage 2 register: output symbol and running disparity
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sym_q <= CTRL_TOKEN_00;
      cnt_q <= '0;
    end else if (en_i) begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// DVI/TMDS encoder: three independent lanes (blue+syncs, green, red) plus aligned data enable.
// Latency: 2 enabled cycles, or 3 when PIPE_OUT is set.
// Backpressure: none; the whole pipeline advances on pxl_clk_en_i and holds otherwise.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int DISP_WIDTH = 6,
  parameter int PIPE_OUT   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pxl_clk_en_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       pixel_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] tmds0_o,
  output logic [9:0] tmds1_o,
  output logic [9:0] tmds2_o,
  output logic       de_o
);

  logic [9:0] sym0;
  logic [9:0] sym1;
  logic [9:0] sym2;
  logic       de_s1;
  logic       de_s2;

  // Channel 0 carries the syncs as C0=hsync, C1=vsync during blanking
  tmds_channel_encoder #(.DISP_WIDTH(DISP_WIDTH)) u_ch0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pxl_clk_en_i),
    .data_i(blue_i),
    .de_i  (pixel_i),
    .c_i   ({vsync_i, hsync_i}),
    .sym_o (sym0)
  );

  tmds_channel_encoder #(.DISP_WIDTH(DISP_WIDTH)) u_ch1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pxl_clk_en_i),
    .data_i(green_i),
    .de_i  (pixel_i),
    .c_i   (2'b00),
    .sym_o (sym1)
  );

  tmds_channel_encoder #(.DISP_WIDTH(DISP_WIDTH)) u_ch2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (pxl_clk_en_i),
    .data_i(red_i),
    .de_i  (pixel_i),
    .c_i   (2'b00),
    .sym_o (sym2)
  );

  // Delay the data enable by the two encoder stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_s1 <= 1'b0;
      de_s2 <= 1'b0;
    end else if (pxl_clk_en_i) begin
      de_s1 <= pixel_i;
      de_s2 <= de_s1;
    end
  end

  if (PIPE_OUT != 0) begin : g_pipe_out
    logic [9:0] sym0_q;
    logic [9:0] sym1_q;
    logic [9:0] sym2_q;
    logic       de_q;

    // Extra output register to ease timing into the serialiser
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sym0_q <= CTRL_TOKEN_00;
        sym1_q <= CTRL_TOKEN_00;
        sym2_q <= CTRL_TOKEN_00;
        de_q   <= 1'b0;
      end else if (pxl_clk_en_i) begin
        sym0_q <= sym0;
        sym1_q <= sym1;
        sym2_q <= sym2;
        de_q   <= de_s2;
      end
    end

    assign tmds0_o = sym0_q;
    assign tmds1_o = sym1_q;
    assign tmds2_o = sym2_q;
    assign de_o    = de_q;
  end else begin : g_direct_out
    assign tmds0_o = sym0;
    assign tmds1_o = sym1;
    assign tmds2_o = sym2;
    assign de_o    = de_s2;
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vector table, clock-enable gating,
// blanking/reset corners and a long random run against a DVI 1.0 reference model.
// Expected symbols are queued when a pixel is driven and compared when it emerges.
module tb_tmds_encoder;

  localparam int         PIPE  = 1;
  localparam int         LAT   = (PIPE != 0) ? 3 : 2;
  localparam logic [9:0] TOK00 = 10'h354;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       pxl_clk_en_i;
  logic [7:0] red_i;
  logic [7:0] green_i;
  logic [7:0] blue_i;
  logic       pixel_i;
  logic       hsync_i;
  logic       vsync_i;
  logic [9:0] tmds0_o;
  logic [9:0] tmds1_o;
  logic [9:0] tmds2_o;
  logic       de_o;

  tmds_encoder #(.DISP_WIDTH(6), .PIPE_OUT(PIPE)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pxl_clk_en_i(pxl_clk_en_i),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .pixel_i     (pixel_i),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .tmds0_o     (tmds0_o),
    .tmds1_o     (tmds1_o),
    .tmds2_o     (tmds2_o),
    .de_o        (de_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [9:0] s0;
    logic [9:0] s1;
    logic [9:0] s2;
    logic       de;
  } exp_t;

  typedef struct {
    logic       en;
    logic       pix;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       chk0;
    logic [9:0] exp0;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t rst_exp;
  int   cnt_m[3];
  int   checks   = 0;
  int   failures = 0;

  // DVI 1.0 reference encoder for one lane, integer arithmetic throughout
  function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic de, input logic [1:0] c,
                                         input int cin, output int cout);
    logic [8:0] qm;
    logic [9:0] o;
    int n1d, n1q, n0q, q8;
    if (!de) begin
      cout = 0;
      case (c)
        2'b00:   o = 10'b1101010100;
        2'b01:   o = 10'b0010101011;
        2'b10:   o = 10'b0101010100;
        default: o = 10'b1010101011;
      endcase
      return o;
    end
    n1d   = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    q8  = qm[8] ? 1 : 0;
    if (cin == 0 || n1q == n0q) begin
      o[9]   = ~qm[8];
      o[8]   = qm[8];
      o[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      cout   = (q8 == 1) ? cin + (n1q - n0q) : cin + (n0q - n1q);
    end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
      o    = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + 2 * q8 + (n0q - n1q);
    end else begin
      o    = {1'b0, qm[8], qm[7:0]};
      cout = cin - 2 * (1 - q8) + (n1q - n0q);
    end
    return o;
  endfunction

  function automatic vec_t mkv(input logic en, input logic pix, input logic hs, input logic vs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic chk0, input logic [9:0] exp0);
    vec_t v;
    v.en = en; v.pix = pix; v.hs = hs; v.vs = vs;
    v.r = r; v.g = g; v.b = b; v.chk0 = chk0; v.exp0 = exp0;
    return v;
  endfunction

  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string tag);
    check10({tag, ".tmds0"}, tmds0_o, e.s0);
    check10({tag, ".tmds1"}, tmds1_o, e.s1);
    check10({tag, ".tmds2"}, tmds2_o, e.s2);
    check1({tag, ".de"}, de_o, e.de);
  endtask

  // Hold reset for ncyc edges with the given enable; outputs must show idle tokens at once
  task automatic do_reset(input int ncyc, input logic en, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_i);
      rst_i        = 1'b1;
      pxl_clk_en_i = en;
      @(posedge clk_i);
      #1;
      check_outputs(rst_exp, tag);
    end
    sb.delete();
    for (int i = 0; i < LAT - 1; i++) sb.push_back(rst_exp);
    last_exp = rst_exp;
    cnt_m    = '{0, 0, 0};
  endtask

  // Drive one clock of stimulus; enabled pixels go through the scoreboard, disabled ones must hold
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    int   co;
    @(negedge clk_i);
    rst_i        = 1'b0;
    pxl_clk_en_i = v.en;
    pixel_i      = v.pix;
    hsync_i      = v.hs;
    vsync_i      = v.vs;
    red_i        = v.r;
    green_i      = v.g;
    blue_i       = v.b;
    if (v.en) begin
      e.s0 = ref_enc(v.b, v.pix, {v.vs, v.hs}, cnt_m[0], co); cnt_m[0] = co;
      e.s1 = ref_enc(v.g, v.pix, 2'b00, cnt_m[1], co);        cnt_m[1] = co;
      e.s2 = ref_enc(v.r, v.pix, 2'b00, cnt_m[2], co);        cnt_m[2] = co;
      if (v.chk0) e.s0 = v.exp0;
      e.de = v.pix;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (v.en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: scoreboard empty, got 0x%03h expected a queued symbol", tag, tmds0_o);
      end else begin
        last_exp = sb.pop_front();
      end
    end
    check_outputs(last_exp, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    logic pix_state;

    rst_i        = 1'b1;
    pxl_clk_en_i = 1'b0;
    pixel_i      = 1'b0;
    hsync_i      = 1'b0;
    vsync_i      = 1'b0;
    red_i        = 8'h00;
    green_i      = 8'h00;
    blue_i       = 8'h00;
    rst_exp.s0 = TOK00; rst_exp.s1 = TOK00; rst_exp.s2 = TOK00; rst_exp.de = 1'b0;
    last_exp = rst_exp;

    //            en    pix   hs    vs    red    green  blue   chk0  exp tmds0
    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h354);
    tbl[1]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h0AB);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 10'h154);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 10'h2AB);
    tbl[4]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'hA3, 8'h00, 1'b1, 10'h100);
    tbl[5]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 8'hFF, 8'h00, 1'b1, 10'h3FF);
    tbl[6]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h81, 8'h00, 1'b1, 10'h100);
    tbl[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h354);
    tbl[8]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'h3C, 8'hFF, 1'b1, 10'h200);
    tbl[9]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h0AB);
    tbl[10] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'hE7, 8'h01, 8'h00, 1'b1, 10'h100);
    tbl[11] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'h7E, 8'hF0, 8'h00, 1'b1, 10'h3FF);

    // Reset held for three edges
    do_reset(3, 1'b1, "reset");

    // Directed table: sync tokens, all-zero run, all-ones, DE fall and restart
    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < LAT; i++)
      step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 10'h000), "flush");

    // Clock enable 1-of-4: same all-zero sequence, garbage on inputs while disabled
    for (int p = 0; p < 3 + LAT; p++) begin
      for (int k = 0; k < 3; k++)
        step(mkv(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 10'h000), "gate_hold");
      if (p < 3)
        step(mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                 (p == 1) ? 10'h3FF : 10'h100), "gate_data");
      else
        step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h354), "gate_blank");
    end

    // Long random run with two mid-stream resets (one with the enable low)
    pix_state = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (i == 3000) do_reset(1, 1'b1, "midrst_en");
      if (i == 7000) do_reset(1, 1'b0, "midrst_noen");
      if ($urandom_range(0, 19) == 0) pix_state = ~pix_state;
      v = mkv(($urandom_range(0, 4) != 0), pix_state, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 10'h000);
      step(v, "random");
    end
    for (int i = 0; i < LAT; i++)
      step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 10'h000), "final_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- DVI/TMDS link encoder directly downstream of the video unit, in the pixel clock domain.
- Consumes the 24-bit colour, hsync, vsync and pixel-enable outputs; produces three 10-bit TMDS symbols per pixel for the serialiser.
- Channel 0 carries blue plus hsync/vsync control; channel 1 carries green; channel 2 carries red.
- Implements the DVI 1.0 transition-minimising and DC-balancing algorithm, with a running disparity counter per channel.

Parameters:
- DISP_WIDTH, 6, width of the signed running-disparity counter (two's complement, no saturation).
- PIPE_OUT, 1, when 1 adds an output register stage. Latency is 2 enabled cycles when PIPE_OUT=0 and 3 when PIPE_OUT=1.

Ports:
- clk_i  input  1  pixel clock; single clock, all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- pxl_clk_en_i  input  1  pixel clock enable; registers advance only when high.
- red_i  input  8  red component (video unit red_o).
- green_i  input  8  green component.
- blue_i  input  8  blue component.
- pixel_i  input  1  data enable (video unit pixel_o); 1 = active video.
- hsync_i  input  1  hsync, already polarity-applied.
- vsync_i  input  1  vsync, already polarity-applied.
- tmds0_o  output  10  channel 0 symbol (blue / hsync, vsync); bit 0 transmitted first.
- tmds1_o  output  10  channel 1 symbol (green).
- tmds2_o  output  10  channel 2 symbol (red).
- de_o  output  1  pixel_i delayed to align with the symbols.

Behaviour:
- Reset: on a clk_i edge with rst_i=1, regardless of pxl_clk_en_i:
  - all tmdsN_o = 10'b1101010100 (control token C1C0=00);
  - de_o=0;
  - all disparity counters = 0;
  - all pipeline DE/control registers cleared.
  - Reset mid-frame discards in-flight pixels; control tokens are emitted until new inputs propagate.
- pxl_clk_en_i=0: every register holds, including disparity counters and outputs.
- Stage 1 (per channel), with N1(D) = popcount of the 8-bit input:
  - If N1>4, or N1==4 and D[0]==0: XNOR path. q_m[0]=D[0]; q_m[i]=~(q_m[i-1]^D[i]); q_m[8]=0.
  - Otherwise: XOR path. q_m[i]=q_m[i-1]^D[i]; q_m[8]=1.
  - Register q_m, popcount(q_m[7:0]) as n1, and 8-n1 as n0, together with DE, C0 and C1.
- Stage 2, when DE=1 (cnt = disparity counter):
  - If cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2*q_m[8] + (n0-n1).
  - Else:
    - out = {0, q_m[8], q_m[7:0]};
    - cnt += -2*(~q_m[8]) + (n1-n0).
- Stage 2, when DE=0:
  - cnt is forced to 0.
  - out = control token selected by {C1,C0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - Channel 0 uses C0=hsync, C1=vsync; channels 1 and 2 use C1C0=00.
- Arithmetic: all disparity arithmetic is signed DISP_WIDTH. The counter magnitude never exceeds 10, so no overflow handling is needed.
- DE transitions: on a 0→1 edge, the first data symbol starts from cnt=0. On a 1→0 edge, the control token is emitted in the same stage-2 cycle that DE=0 arrives.
- Sync pass-through: hsync/vsync are encoded into channel-0 tokens only during DE=0. During DE=1 they are ignored.
- Per-channel independence: the three channels are independent and share only the control pipeline and the enable.

Decomposition:
- Package tmds_pkg:
  - localparams CTRL_TOKEN_00/01/10/11 (10-bit);
  - typedef tmds_sym_t (logic [9:0]);
  - function popcount8.
- Sub-module tmds_channel_encoder, instantiated 3×:
  - inputs: clk_i, rst_i, en_i, data_i[7:0], de_i, c_i[1:0];
  - output: sym_o[9:0];
  - contains both stages and its own disparity counter.
- Top level contains only the instances, the de_o delay and the optional PIPE_OUT register.

Test Plan:
- Reset and blanking:
  - Stimulus: hold rst_i=1 for 3 cycles, then release with pixel_i=0, hsync_i=0, vsync_i=0.
  - Required: all tmdsN_o=0x354 (1101010100) and de_o=0 throughout.
  - Then set hsync_i=1: tmds0_o=0x0AB after latency, while tmds1_o and tmds2_o stay 0x354.
- All-zero data:
  - Stimulus: pixel_i=1, blue_i=0x00 for 3 consecutive enabled pixels.
  - Required: tmds0_o sequence 0x100, 0x3FF, 0x100; internal cnt values −8, +2, −6.
- All-ones data:
  - Stimulus: blue_i=0xFF at cnt=0.
  - Required: tmds0_o=0x200, cnt=−8.
- Clock enable gating:
  - Stimulus: toggle pxl_clk_en_i in a 1-of-4 pattern while feeding the scenario-2 data.
  - Required: identical symbol sequence, with each symbol held for 4 clk_i cycles; latency counted in enabled cycles.
- DE falling edge:
  - Stimulus: end active video after a pixel leaves cnt≠0, then restart active video with blue_i=0x00.
  - Required: control tokens emitted during blanking; first new data symbol is 0x100, proving cnt was reset to 0.
- Mid-stream reset and reference model:
  - Stimulus: assert rst_i for one cycle during random active pixels.
  - Required: next output is 0x354 on all channels with de_o=0.
  - Additionally: 10k random pixels compared bit-exactly against the DVI 1.0 reference model on all three channels.
